// File: rtl/kronos_types.sv
// Shared execute-side types: per-operand hazard flags from the HCU and the
// operand-staging FSM states.
package kronos_types;

   typedef struct packed {
      logic op_hazard;
      logic op4;
      logic op3;
      logic op2;
      logic op1;
   } hazardEX_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      WAIT  = 2'd1,
      FULL  = 2'd2
   } opstage_state_e;

endpackage

// File: rtl/kronos_opfwd_mux.sv
// Per-operand forward selector: flagged operand takes the writeback result when it is valid.
// Purely combinational, no backpressure.
module kronos_opfwd_mux #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_op,
   input  logic            i_flag,
   input  logic            i_fwd_vld,
   input  logic [XLEN-1:0] i_fwd_data,
   output logic [XLEN-1:0] o_op
);

   assign o_op = (i_flag && i_fwd_vld) ? i_fwd_data : i_op;

endmodule

// File: rtl/kronos_ex_opstage.sv
// Execute operand staging: holds a hazarded instruction until the writeback forward arrives.
// Latency 1 cycle accept->o_vld (plus WAIT cycles); d_rdy follows o_rdy combinationally when FULL.
module kronos_ex_opstage
   import kronos_types::*;
#(
   parameter int XLEN    = 32,
   parameter int STALL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               d_vld,
   output logic               d_rdy,
   input  logic [XLEN-1:0]    d_op1,
   input  logic [XLEN-1:0]    d_op2,
   input  logic [XLEN-1:0]    d_op3,
   input  logic [XLEN-1:0]    d_op4,
   input  hazardEX_t          d_hazard,
   input  logic               fwd_vld,
   input  logic [XLEN-1:0]    fwd_data,
   output logic               o_vld,
   input  logic               o_rdy,
   output logic [XLEN-1:0]    o_op1,
   output logic [XLEN-1:0]    o_op2,
   output logic [XLEN-1:0]    o_op3,
   output logic [XLEN-1:0]    o_op4,
   output logic [STALL_W-1:0] stall_cnt
);

   opstage_state_e     r_state;
   opstage_state_e     w_state_nxt;
   logic [XLEN-1:0]    r_op [4];
   hazardEX_t          r_haz;
   logic [STALL_W-1:0] r_stall_cnt;

   logic               w_accept;
   logic               w_cap_wait;
   logic               w_fwd_en;
   logic [XLEN-1:0]    w_src_op [4];
   logic [3:0]         w_src_flag;
   logic [XLEN-1:0]    w_res_op [4];

   assign w_accept   = d_vld && d_rdy;
   // A captured hazard with no same-cycle forward has to park in WAIT.
   assign w_cap_wait = d_hazard.op_hazard && !fwd_vld;
   assign w_fwd_en   = w_accept ? (fwd_vld && d_hazard.op_hazard)
                                : (fwd_vld && r_state == WAIT);

   assign w_src_op[0] = w_accept ? d_op1 : r_op[0];
   assign w_src_op[1] = w_accept ? d_op2 : r_op[1];
   assign w_src_op[2] = w_accept ? d_op3 : r_op[2];
   assign w_src_op[3] = w_accept ? d_op4 : r_op[3];
   assign w_src_flag  = w_accept ? {d_hazard.op4, d_hazard.op3, d_hazard.op2, d_hazard.op1}
                                 : {r_haz.op4, r_haz.op3, r_haz.op2, r_haz.op1};

   for (genvar g = 0; g < 4; g++) begin : g_fwd
      kronos_opfwd_mux #(.XLEN(XLEN)) u_mux (
         .i_op       (w_src_op[g]),
         .i_flag     (w_src_flag[g]),
         .i_fwd_vld  (w_fwd_en),
         .i_fwd_data (fwd_data),
         .o_op       (w_res_op[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= EMPTY;
         r_haz       <= '0;
         r_stall_cnt <= '0;
         for (int i = 0; i < 4; i++) r_op[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept || r_state == WAIT) begin
            for (int i = 0; i < 4; i++) r_op[i] <= w_res_op[i];
         end
         if (w_accept) begin
            r_haz <= w_cap_wait ? d_hazard : '0;
         end else if (r_state == WAIT && fwd_vld) begin
            r_haz <= '0;
         end
         if (r_state == WAIT && !fwd_vld && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY: if (w_accept) w_state_nxt = w_cap_wait ? WAIT : FULL;
         WAIT:  if (fwd_vld) w_state_nxt = FULL;
         FULL: begin
            if (w_accept)   w_state_nxt = w_cap_wait ? WAIT : FULL;
            else if (o_rdy) w_state_nxt = EMPTY;
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   always_comb begin
      o_vld = (r_state == FULL);
      d_rdy = !rst && (r_state == EMPTY || (r_state == FULL && o_rdy));
   end

   assign o_op1     = r_op[0];
   assign o_op2     = r_op[1];
   assign o_op3     = r_op[2];
   assign o_op4     = r_op[3];
   assign stall_cnt = r_stall_cnt;

endmodule
